// File: rtl/fifo.sv
// Synchronous FWFT flit FIFO: a write is visible on pkto one cycle later; pkto is combinational from storage.
// A push while full is dropped unless a pop happens in the same cycle. FIFO_NULL_FILTER_EN discards null flits at the input.
module fifo #(
    parameter int PKTW  = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic [PKTW:0] pkti,
    output logic          empty,
    output logic          full,
    output logic [PKTW:0] pkto
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PKTW:0] mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [AW:0]   cnt;
    logic          we_eff;
    logic          wr_ok;
    logic          rd_ok;

`ifdef FIFO_NULL_FILTER_EN
    assign we_eff = we && (pkti[PKTW:PKTW-1] != 2'b00);
`else
    assign we_eff = we;
`endif

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign rd_ok = re && !empty;
    // A full FIFO still accepts a write when a pop frees the head slot this cycle.
    assign wr_ok = we_eff && (!full || re);
    assign pkto  = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (rd_ok) rp <= rp + 1'b1;
            if (wr_ok) wp <= wp + 1'b1;
            if (wr_ok && !rd_ok)
                cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wp] <= pkti;
    end

endmodule

// File: tb/tb_fifo.sv
// Randomized and directed checking of fifo against a queue-based reference model.
module tb_fifo;

    localparam int PKTW  = 9;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          re;
    logic          we;
    logic [PKTW:0] pkti;
    logic          empty;
    logic          full;
    logic [PKTW:0] pkto;

    int passed = 0;
    int total  = 0;
    logic [PKTW:0] q[$];

    fifo #(.PKTW(PKTW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .pkti(pkti),
        .empty(empty), .full(full), .pkto(pkto)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            passed++;
    endtask

    function automatic bit is_stored(input logic [PKTW:0] d);
`ifdef FIFO_NULL_FILTER_EN
        return d[PKTW:PKTW-1] != 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle from a negedge, advance the model, then compare at the next negedge.
    task automatic step(input logic r, input logic w, input logic [PKTW:0] d, input logic rs);
        bit acc_r, acc_w;
        re = r; we = w; pkti = d; rst = rs;
        if (rs) begin
            q.delete();
        end else begin
            acc_r = r && (q.size() > 0);
            acc_w = w && is_stored(d) && ((q.size() < DEPTH) || r);
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        re = 0; we = 0; rst = 0;
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full",  32'(full),  32'(q.size() == DEPTH));
        check("pkto",  32'(pkto),  (q.size() == 0) ? 32'd0 : 32'(q[0]));
    endtask

    logic [PKTW:0] stream [5];
    logic [PKTW:0] seen[$];

    initial begin
        clk = 0; rst = 1; re = 0; we = 0; pkti = '0;
        stream[0] = 10'b10_00000011;
        stream[1] = 10'b01_00000000;
        stream[2] = 10'b01_00000001;
        stream[3] = 10'b01_00000010;
        stream[4] = 10'b11_00000000;
        @(negedge clk);

        // reset held two cycles
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        check("rst_pkto", 32'(pkto), 32'h0);

        // single write, visible next cycle
        step(0, 1, 10'b10_00000011, 0);
        check("wr1_pkto", 32'(pkto), 32'h203);

        // packet stream with reads starting on third write
        step(0, 0, '0, 1);
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            if (i >= 2 && !empty) seen.push_back(pkto);
            step(i >= 2, 1, stream[i], 0);
        end
        for (int i = 0; i < 8 && !empty; i++) begin
            seen.push_back(pkto);
            step(1, 0, '0, 0);
        end
        check("stream_len", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            check("stream_ord", 32'(seen[i]), 32'(stream[i]));

        // fill, dropped fifth write, drain
        step(0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 10'h100 + 10'(i), 0);
        step(0, 1, 10'h3AA, 0);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0);

        // full with simultaneous read/write, then empty with simultaneous read/write
        for (int i = 0; i < 4; i++) step(0, 1, 10'h240 + 10'(i), 0);
        step(1, 1, 10'h3C5, 0);
        step(0, 0, '0, 1);
        step(1, 1, 10'h2F0, 0);

        // pointer wrap-around then mid-stream reset
        step(0, 0, '0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 10'h080 + 10'(i), 0);
            step(1, 1, 10'h1C0 + 10'(i), 0);
            step(1, 0, '0, 0);
        end
        step(0, 1, 10'h155, 0);
        step(0, 1, 10'h156, 0);
        step(0, 0, '0, 1);

        // null flit: stored unless the filter is compiled in
        step(0, 1, 10'h000, 0);
        step(0, 0, '0, 1);
        step(0, 1, 10'b00_01010101, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 10'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
